// File: rtl/ro_sel_pkg.sv
// Shared definitions for the RO select decoder: FSM state encoding and
// default widths used by the top-level parameters.
package ro_sel_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GUARD  = 2'd2
   } state_t;

   localparam int DWELL_W_DEF      = 16;
   localparam int GUARD_CYCLES_DEF = 2;

   // A request is legal only for an existing RO and a non-zero dwell.
   function automatic logic req_legal(input logic in_range, input logic dwell_nz);
      return in_range & dwell_nz;
   endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational index -> one-hot decoder with an in-range flag; an index at or
// beyond DEPTH yields an all-zero vector and in_range low.
module onehot_dec #(
   parameter int DEPTH = 4,
   parameter int IDX_W = 2
) (
   input  logic [IDX_W-1:0] idx,
   output logic [DEPTH-1:0] onehot,
   output logic             in_range
);

   // Decode one bit per RO; out-of-range indices match no bit.
   always_comb begin
      onehot = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (idx == IDX_W'(i)) begin
            onehot[i] = 1'b1;
         end else begin
            onehot[i] = 1'b0;
         end
      end
      in_range = |onehot;
   end

endmodule

// File: rtl/ro_select_decoder_checker.sv
// Property checker for ro_select_decoder outputs: one-hot enable, READY/BUSY
// complementarity and pulse/state consistency.
module ro_select_decoder_checker #(
   parameter int DEPTH = 4
) (
   input logic             clk,
   input logic             rst_n,
   input logic [DEPTH-1:0] en,
   input logic             ready,
   input logic             busy,
   input logic             done,
   input logic             err,
   input logic             aborted
);

   a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(en));
   a_busy:   assert property (@(posedge clk) disable iff (!rst_n) busy == !ready);
   a_done:   assert property (@(posedge clk) disable iff (!rst_n) done |-> ready);
   a_err:    assert property (@(posedge clk) disable iff (!rst_n) err |-> (ready && en == '0));
   a_abort:  assert property (@(posedge clk) disable iff (!rst_n) aborted |-> en == '0);

endmodule

// File: rtl/ro_select_decoder.sv
// Sequential RO select decoder: accepts (index, dwell) requests, drives a
// registered one-hot enable for the dwell, then an all-off guard interval.
module ro_select_decoder
   import ro_sel_pkg::*;
#(
   parameter int DECODER_DEPTH = 4,
   parameter int log2N         = 2,
   parameter int DWELL_W       = DWELL_W_DEF,
   parameter int GUARD_CYCLES  = GUARD_CYCLES_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [log2N-1:0]         IDX_IN,
   input  logic [DWELL_W-1:0]       DWELL_IN,
   input  logic                     VALID_IN,
   output logic                     READY,
   input  logic                     ABORT,
   output logic [DECODER_DEPTH-1:0] EN_OUT,
   output logic [log2N-1:0]         IDX_ACT,
   output logic                     BUSY,
   output logic                     DONE,
   output logic                     ABORTED,
   output logic                     ERR
);

   localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES + 1) : 1;
   localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES);

   state_t                   state_r, state_s;
   logic [DWELL_W-1:0]       cnt_r, cnt_s;
   logic [GUARD_W-1:0]       gcnt_r, gcnt_s;
   logic [DECODER_DEPTH-1:0] en_r, en_s;
   logic [log2N-1:0]         idx_r, idx_s;
   logic                     done_r, done_s;
   logic                     aborted_r, aborted_s;
   logic                     err_r, err_s;
   logic [DECODER_DEPTH-1:0] req_onehot_s;
   logic                     req_in_range_s;
   logic                     dwell_nz_s;

   onehot_dec #(
      .DEPTH (DECODER_DEPTH),
      .IDX_W (log2N)
   ) u_dec (
      .idx      (IDX_IN),
      .onehot   (req_onehot_s),
      .in_range (req_in_range_s)
   );

   assign dwell_nz_s = |DWELL_IN;

   // Next-state, counter and pulse logic; pulses default low every cycle.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      gcnt_s    = gcnt_r;
      en_s      = en_r;
      idx_s     = idx_r;
      done_s    = 1'b0;
      aborted_s = 1'b0;
      err_s     = 1'b0;
      case (state_r)
         IDLE: begin
            en_s = '0;
            if (VALID_IN) begin
               if (req_legal(req_in_range_s, dwell_nz_s)) begin
                  en_s    = req_onehot_s;
                  idx_s   = IDX_IN;
                  cnt_s   = DWELL_IN;
                  state_s = ACTIVE;
               end else begin
                  err_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ACTIVE: begin
            // Abort wins over natural expiry; both end the dwell on this edge.
            if (ABORT || (cnt_r == DWELL_W'(1))) begin
               en_s      = '0;
               cnt_s     = '0;
               aborted_s = ABORT;
               if (GUARD_CYCLES > 0) begin
                  gcnt_s  = GUARD_LOAD;
                  state_s = GUARD;
               end else begin
                  done_s  = 1'b1;
                  state_s = IDLE;
               end
            end else begin
               cnt_s = cnt_r - DWELL_W'(1);
            end
         end
         GUARD: begin
            en_s = '0;
            if (gcnt_r <= GUARD_W'(1)) begin
               gcnt_s  = '0;
               done_s  = 1'b1;
               state_s = IDLE;
            end else begin
               gcnt_s = gcnt_r - GUARD_W'(1);
            end
         end
         default: begin
            state_s = IDLE;
            en_s    = '0;
            cnt_s   = '0;
            gcnt_s  = '0;
         end
      endcase
   end

   // State and output registers; reset clears the enables asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         gcnt_r    <= '0;
         en_r      <= '0;
         idx_r     <= '0;
         done_r    <= 1'b0;
         aborted_r <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         gcnt_r    <= gcnt_s;
         en_r      <= en_s;
         idx_r     <= idx_s;
         done_r    <= done_s;
         aborted_r <= aborted_s;
         err_r     <= err_s;
      end
   end

   assign EN_OUT  = en_r;
   assign IDX_ACT = idx_r;
   assign DONE    = done_r;
   assign ABORTED = aborted_r;
   assign ERR     = err_r;
   assign READY   = (state_r == IDLE);
   assign BUSY    = ~READY;

endmodule

// File: tb/tb_ro_select_decoder.sv
// Directed self-checking bench for ro_select_decoder with three configurations:
// nominal (4 ROs, guard 2), 3 ROs with 4-bit dwell, and guard 0.
module tb_ro_select_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  idx = 2'd0;
   logic [15:0] dwell = 16'd0;
   logic        abort = 1'b0;
   logic        valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
   int          checks = 0;
   int          errors = 0;

   logic [3:0] en_a, en_c;
   logic [2:0] en_b;
   logic [1:0] idx_act_a, idx_act_b, idx_act_c;
   logic ready_a, busy_a, done_a, aborted_a, err_a;
   logic ready_b, busy_b, done_b, aborted_b, err_b;
   logic ready_c, busy_c, done_c, aborted_c, err_c;

   always #5 clk = ~clk;

   ro_select_decoder #(.DECODER_DEPTH(4), .log2N(2), .DWELL_W(16), .GUARD_CYCLES(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .IDX_IN(idx), .DWELL_IN(dwell), .VALID_IN(valid_a),
      .READY(ready_a), .ABORT(abort), .EN_OUT(en_a), .IDX_ACT(idx_act_a), .BUSY(busy_a),
      .DONE(done_a), .ABORTED(aborted_a), .ERR(err_a));

   ro_select_decoder #(.DECODER_DEPTH(3), .log2N(2), .DWELL_W(4), .GUARD_CYCLES(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .IDX_IN(idx), .DWELL_IN(dwell[3:0]), .VALID_IN(valid_b),
      .READY(ready_b), .ABORT(abort), .EN_OUT(en_b), .IDX_ACT(idx_act_b), .BUSY(busy_b),
      .DONE(done_b), .ABORTED(aborted_b), .ERR(err_b));

   ro_select_decoder #(.DECODER_DEPTH(4), .log2N(2), .DWELL_W(4), .GUARD_CYCLES(0)) dut_c (
      .clk(clk), .rst_n(rst_n), .IDX_IN(idx), .DWELL_IN(dwell[3:0]), .VALID_IN(valid_c),
      .READY(ready_c), .ABORT(abort), .EN_OUT(en_c), .IDX_ACT(idx_act_c), .BUSY(busy_c),
      .DONE(done_c), .ABORTED(aborted_c), .ERR(err_c));

   ro_select_decoder_checker #(.DEPTH(4)) chk_a (
      .clk(clk), .rst_n(rst_n), .en(en_a), .ready(ready_a), .busy(busy_a),
      .done(done_a), .err(err_a), .aborted(aborted_a));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({en_a, idx_act_a, ready_a, busy_a, done_a, aborted_a, err_a} !== 11'b0000_00_1_0_000) begin
         errors++;
         $display("FAIL reset_state got en=%b idx=%0d rdy=%b busy=%b done=%b ab=%b err=%b exp en=0 idx=0 rdy=1 others 0",
                  en_a, idx_act_a, ready_a, busy_a, done_a, aborted_a, err_a);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_nominal();
      idx = 2'd2; dwell = 16'd5; valid_a = 1'b1;
      tick();
      valid_a = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (en_a !== 4'b0100 || ready_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL nominal_en cycle %0d got en=%b rdy=%b exp en=0100 rdy=0", k, en_a, ready_a);
         end
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (en_a !== 4'b0000 || done_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL nominal_guard cycle %0d got en=%b done=%b busy=%b exp en=0 done=0 busy=1", k, en_a, done_a, busy_a);
         end
         tick();
      end
      checks++;
      if (done_a !== 1'b1 || ready_a !== 1'b1 || idx_act_a !== 2'd2 || en_a !== 4'b0000) begin
         errors++;
         $display("FAIL nominal_done got done=%b rdy=%b idx=%0d en=%b exp done=1 rdy=1 idx=2 en=0", done_a, ready_a, idx_act_a, en_a);
      end
      tick();
      checks++;
      if (done_a !== 1'b0) begin
         errors++;
         $display("FAIL nominal_done_pulse got done=%b exp 0", done_a);
      end
   endtask

   task automatic test_reject();
      idx = 2'd3; dwell = 16'd5; valid_b = 1'b1;
      tick();
      valid_b = 1'b0;
      checks++;
      if (err_b !== 1'b1 || en_b !== 3'b000 || ready_b !== 1'b1 || done_b !== 1'b0) begin
         errors++;
         $display("FAIL reject_idx got err=%b en=%b rdy=%b done=%b exp err=1 en=0 rdy=1 done=0", err_b, en_b, ready_b, done_b);
      end
      tick();
      checks++;
      if (err_b !== 1'b0 || ready_b !== 1'b1) begin
         errors++;
         $display("FAIL reject_idx_pulse got err=%b rdy=%b exp err=0 rdy=1", err_b, ready_b);
      end
      idx = 2'd1; dwell = 16'd0; valid_a = 1'b1;
      tick();
      valid_a = 1'b0;
      checks++;
      if (err_a !== 1'b1 || en_a !== 4'b0000 || ready_a !== 1'b1 || done_a !== 1'b0) begin
         errors++;
         $display("FAIL reject_dwell got err=%b en=%b rdy=%b done=%b exp err=1 en=0 rdy=1 done=0", err_a, en_a, ready_a, done_a);
      end
      tick();
      checks++;
      if (err_a !== 1'b0 || en_a !== 4'b0000) begin
         errors++;
         $display("FAIL reject_dwell_pulse got err=%b en=%b exp err=0 en=0", err_a, en_a);
      end
   endtask

   task automatic test_abort();
      idx = 2'd1; dwell = 16'd100; valid_a = 1'b1;
      tick();
      valid_a = 1'b0;
      for (int k = 1; k < 10; k++) tick();
      checks++;
      if (en_a !== 4'b0010) begin
         errors++;
         $display("FAIL abort_pre got en=%b exp 0010", en_a);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (en_a !== 4'b0000 || aborted_a !== 1'b1 || busy_a !== 1'b1) begin
         errors++;
         $display("FAIL abort_take got en=%b ab=%b busy=%b exp en=0 ab=1 busy=1", en_a, aborted_a, busy_a);
      end
      tick();
      checks++;
      if (aborted_a !== 1'b0 || done_a !== 1'b0 || en_a !== 4'b0000) begin
         errors++;
         $display("FAIL abort_guard got ab=%b done=%b en=%b exp 0 0 0", aborted_a, done_a, en_a);
      end
      tick();
      checks++;
      if (done_a !== 1'b1 || ready_a !== 1'b1) begin
         errors++;
         $display("FAIL abort_done got done=%b rdy=%b exp 1 1", done_a, ready_a);
      end
      // abort on the final dwell cycle, then held high through the guard
      idx = 2'd3; dwell = 16'd3; valid_a = 1'b1;
      tick();
      valid_a = 1'b0;
      tick();
      tick();
      abort = 1'b1;
      tick();
      checks++;
      if (aborted_a !== 1'b1 || en_a !== 4'b0000) begin
         errors++;
         $display("FAIL abort_last got ab=%b en=%b exp ab=1 en=0", aborted_a, en_a);
      end
      tick();
      checks++;
      if (aborted_a !== 1'b0 || done_a !== 1'b0) begin
         errors++;
         $display("FAIL abort_in_guard got ab=%b done=%b exp 0 0", aborted_a, done_a);
      end
      tick();
      abort = 1'b0;
      checks++;
      if (done_a !== 1'b1 || aborted_a !== 1'b0) begin
         errors++;
         $display("FAIL abort_last_done got done=%b ab=%b exp done=1 ab=0", done_a, aborted_a);
      end
      // abort together with valid in IDLE does not block acceptance
      idx = 2'd0; dwell = 16'd2; valid_a = 1'b1; abort = 1'b1;
      tick();
      valid_a = 1'b0; abort = 1'b0;
      checks++;
      if (en_a !== 4'b0001 || aborted_a !== 1'b0 || err_a !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle got en=%b ab=%b err=%b exp en=0001 ab=0 err=0", en_a, aborted_a, err_a);
      end
      for (int k = 0; k < 4; k++) tick();
      checks++;
      if (done_a !== 1'b1) begin
         errors++;
         $display("FAIL abort_idle_done got done=%b exp 1", done_a);
      end
   endtask

   task automatic test_max_dwell();
      idx = 2'd2; dwell = 16'd15; valid_b = 1'b1;
      tick();
      valid_b = 1'b0;
      for (int k = 0; k < 15; k++) begin
         checks++;
         if (en_b !== 3'b100) begin
            errors++;
            $display("FAIL max_dwell_en cycle %0d got en=%b exp 100", k, en_b);
         end
         tick();
      end
      checks++;
      if (en_b !== 3'b000 || busy_b !== 1'b1) begin
         errors++;
         $display("FAIL max_dwell_end got en=%b busy=%b exp en=0 busy=1", en_b, busy_b);
      end
      tick();
      tick();
      checks++;
      if (done_b !== 1'b1 || idx_act_b !== 2'd2) begin
         errors++;
         $display("FAIL max_dwell_done got done=%b idx=%0d exp done=1 idx=2", done_b, idx_act_b);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_seq [6];
      logic [5:0] exp_done;
      exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b0001;
      exp_seq[3] = 4'b0000; exp_seq[4] = 4'b1000; exp_seq[5] = 4'b0000;
      exp_done = 6'b101000;
      idx = 2'd0; dwell = 16'd3; valid_c = 1'b1;
      tick();
      idx = 2'd3; dwell = 16'd1;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (en_c !== exp_seq[k] || done_c !== exp_done[k] || $countones(en_c) > 1) begin
            errors++;
            $display("FAIL b2b cycle %0d got en=%b done=%b exp en=%b done=%b", k, en_c, done_c, exp_seq[k], exp_done[k]);
         end
         if (k == 4) valid_c = 1'b0;
         tick();
      end
   endtask

   task automatic test_reset_mid_dwell();
      idx = 2'd2; dwell = 16'd50; valid_a = 1'b1;
      tick();
      valid_a = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({en_a, idx_act_a, ready_a, busy_a, done_a, aborted_a, err_a} !== 11'b0000_00_1_0_000) begin
         errors++;
         $display("FAIL reset_mid got en=%b idx=%0d rdy=%b busy=%b done=%b ab=%b err=%b exp en=0 idx=0 rdy=1 others 0",
                  en_a, idx_act_a, ready_a, busy_a, done_a, aborted_a, err_a);
      end
      #2;
      rst_n = 1'b1;
      tick();
      checks++;
      if (ready_a !== 1'b1 || en_a !== 4'b0000) begin
         errors++;
         $display("FAIL reset_release got rdy=%b en=%b exp rdy=1 en=0", ready_a, en_a);
      end
   endtask

   task automatic test_random();
      int accepted = 0;
      int done_cnt = 0;
      int r_dw, r_ab, len;
      logic [1:0] r_idx;
      logic [3:0] exp_en;
      for (int n = 0; n < 1000; n++) begin
         r_idx = 2'($urandom_range(0, 3));
         r_dw  = $urandom_range(0, 12);
         r_ab  = $urandom_range(0, 16);
         idx = r_idx; dwell = 16'(r_dw); valid_a = 1'b1;
         tick();
         valid_a = 1'b0;
         if (r_dw == 0) begin
            checks++;
            if (err_a !== 1'b1 || en_a !== 4'b0000 || done_a !== 1'b0) begin
               errors++;
               $display("FAIL rand_reject req %0d got err=%b en=%b exp err=1 en=0", n, err_a, en_a);
            end
         end else begin
            accepted++;
            exp_en = 4'b0001 << r_idx;
            len = (r_ab != 0 && r_ab <= r_dw) ? r_ab : r_dw;
            for (int k = 1; k <= len; k++) begin
               checks++;
               if (en_a !== exp_en || idx_act_a !== r_idx || busy_a !== 1'b1) begin
                  errors++;
                  $display("FAIL rand_dwell req %0d cycle %0d got en=%b idx=%0d exp en=%b idx=%0d", n, k, en_a, idx_act_a, exp_en, r_idx);
               end
               if (k == r_ab) abort = 1'b1;
               tick();
               abort = 1'b0;
            end
            checks++;
            if (en_a !== 4'b0000 || aborted_a !== (len == r_ab)) begin
               errors++;
               $display("FAIL rand_end req %0d got en=%b ab=%b exp en=0 ab=%b", n, en_a, aborted_a, (len == r_ab));
            end
            tick();
            checks++;
            if (en_a !== 4'b0000 || done_a !== 1'b0 || busy_a !== 1'b1) begin
               errors++;
               $display("FAIL rand_guard req %0d got en=%b done=%b busy=%b exp 0 0 1", n, en_a, done_a, busy_a);
            end
            tick();
            if (done_a === 1'b1) done_cnt++;
            checks++;
            if (done_a !== 1'b1 || ready_a !== 1'b1 || en_a !== 4'b0000) begin
               errors++;
               $display("FAIL rand_done req %0d got done=%b rdy=%b en=%b exp 1 1 0", n, done_a, ready_a, en_a);
            end
         end
      end
      checks++;
      if (done_cnt != accepted) begin
         errors++;
         $display("FAIL rand_done_count got %0d exp %0d", done_cnt, accepted);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_reject();
      test_abort();
      test_max_dwell();
      test_back_to_back();
      test_reset_mid_dwell();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ro_select_decoder.md
Name: ro_select_decoder

Overview:
- Index-to-one-hot sequential decoder. It is the inverse of the bank's priority encoder (vector -> index).
- Accepts a ring-oscillator index and a dwell length over a valid/ready handshake.
- Drives a registered one-hot enable to exactly one RO for the dwell time, then holds all enables low for a guard interval so oscillations decay before the next selection.
- Sits between the measurement controller and the RO bank enable inputs.

Parameters:
- DECODER_DEPTH, 4: number of ROs / width of the one-hot enable vector.
- log2N, 2: index width; must satisfy 2**log2N >= DECODER_DEPTH.
- DWELL_W, 16: width of the dwell-length input and the dwell counter.
- GUARD_CYCLES, 2: all-off cycles after each dwell; 0 is legal.

Ports:
- clk, in, 1: system clock; all state updates on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- IDX_IN, in, log2N: RO index to enable.
- DWELL_IN, in, DWELL_W: enable duration in clk cycles.
- VALID_IN, in, 1: request valid.
- READY, out, 1: block can accept a request.
- ABORT, in, 1: terminate the current dwell early.
- EN_OUT, out, DECODER_DEPTH: registered one-hot RO enable.
- IDX_ACT, out, log2N: index currently or last enabled.
- BUSY, out, 1: state is not IDLE.
- DONE, out, 1: one-cycle pulse when the sequence returns to IDLE.
- ABORTED, out, 1: one-cycle pulse when an abort is taken.
- ERR, out, 1: one-cycle pulse when a request is rejected.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; EN_OUT=0, IDX_ACT=0, both counters 0.
  - DONE=ABORTED=ERR=0; READY=1, BUSY=0.
  - Reset mid-dwell clears EN_OUT immediately (asynchronously).
- All outputs are registered except READY=(state==IDLE) and BUSY=!READY.
- FSM states: IDLE, ACTIVE, GUARD.
- IDLE:
  - Handshake is VALID_IN&&READY at a rising edge (edge e0).
  - Reject if IDX_IN>=DECODER_DEPTH or DWELL_IN==0: ERR=1 for one cycle from e0, stay IDLE, EN_OUT unchanged (0).
  - Otherwise latch the index into IDX_ACT, load the dwell counter with DWELL_IN, set EN_OUT[IDX_IN]=1 at e0, go ACTIVE. Latency request -> enable is 1 edge.
- ACTIVE:
  - Dwell counter decrements each edge. EN_OUT stays high for exactly DWELL_IN cycles and is cleared at edge e0+DWELL_IN.
  - At that edge: if GUARD_CYCLES>0, load the guard counter and go GUARD; else go IDLE with DONE=1.
- GUARD:
  - EN_OUT=0; guard counter decrements.
  - At edge e0+DWELL_IN+GUARD_CYCLES go IDLE, DONE=1 for one cycle. READY is high in the same cycle as DONE.
- ABORT:
  - Sampled only in ACTIVE. EN_OUT is cleared at the next edge, ABORTED=1 for one cycle, and the block enters GUARD (or IDLE with DONE if GUARD_CYCLES=0).
  - ABORT has priority over natural dwell expiry on the same edge.
  - The full guard interval is always honoured after an abort.
  - ABORT in IDLE or GUARD is ignored; ABORT together with VALID_IN in IDLE has no effect on acceptance.
- Back-to-back: a new request can be accepted at the edge after DONE. At least GUARD_CYCLES zero cycles always separate two enables.
- Invariant: $countones(EN_OUT)<=1 in every cycle.
- DWELL_IN is sampled only at acceptance; later changes have no effect.
- DWELL_IN max (2**DWELL_W-1) is legal; no wrap-around.

Decomposition:
- Shared package ro_sel_pkg holds:
  - state encoding constants (IDLE=2'd0, ACTIVE=2'd1, GUARD=2'd2);
  - default widths DWELL_W=16, GUARD_CYCLES=2.
- One sub-module, onehot_dec: a combinational index -> one-hot function with in-range flag. It is reused for range checking and EN_OUT generation.
- Counters and the FSM stay in the top module.

Test Plan:
- Nominal: reset, then IDX_IN=2, DWELL_IN=5, VALID 1 cycle.
  - Expect EN_OUT=4'b0100 for exactly 5 cycles starting at the accept edge, then 0 for 2 cycles.
  - Expect DONE pulse and READY=1 at edge 7; IDX_ACT=2.
- Reject: IDX_IN=3 with DECODER_DEPTH=3, or DWELL_IN=0.
  - Expect ERR pulse 1 cycle, EN_OUT=0, READY stays 1, no DONE.
- Abort: IDX_IN=1, DWELL_IN=100, ABORT at the 10th active cycle.
  - Expect EN_OUT cleared at the next edge, ABORTED pulse, 2 guard cycles, then DONE.
  - ABORT on the final dwell cycle still produces an ABORTED pulse.
- Back-to-back with GUARD_CYCLES=0 and VALID held high: requests (0,3) then (3,1).
  - Expect EN_OUT 0001 x3, one IDLE cycle at 0 with DONE, then 1000 x1.
  - Never two bits high at once.
- Reset mid-dwell: assert rst_n=0 asynchronously during ACTIVE.
  - Expect EN_OUT=0 before the next clk edge, all pulses 0, READY=1 after release.
- Random: 1000 random requests and aborts checked against a reference model.
  - Checks: one-hot invariant, dwell length exact, guard gap >= GUARD_CYCLES, DONE count == accepted count.
